// File: rtl/rasterizer_pkg.sv
// ---------------------------------------------------------------------------
// rasterizer_pkg
// Shared types for the rasterizer scheduling slice.
//   sched_state_t : frame scheduler states (IDLE / RUN / DONE)
//   tri_setup_t   : one finished triangle setup (bounding box, edge values,
//                   edge deltas, 1/area), each field SETUP_DW bits wide
//   idx_width()   : index width for an N-way selector (at least 1 bit)
// ---------------------------------------------------------------------------
package rasterizer_pkg;

    localparam int unsigned SETUP_DW = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [1:0][SETUP_DW-1:0]      bb_tl;
        logic [1:0][SETUP_DW-1:0]      bb_br;
        logic [2:0][SETUP_DW-1:0]      edge_val;
        logic [2:0][1:0][SETUP_DW-1:0] edge_delta;
        logic [SETUP_DW-1:0]           area_inv;
    } tri_setup_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set bit of `free` at or after
// `ptr`, wrapping modulo N.
//   free  in  N   candidates that may be granted
//   ptr   in  IW  rotation start index (0..N-1)
//   grant out N   one-hot grant (all zero when nothing is free)
//   idx   out IW  index of the granted bit
//   valid out 1   some candidate was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  free,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!valid && free[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
                grant = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/rasterizer_scheduler.sv
// ---------------------------------------------------------------------------
// rasterizer_scheduler
// Runs one frame of triangles through the rasterizer front-end and hands each
// finished setup to the next free back-end in round-robin order.
//   clk, rstn            clock, asynchronous active-low reset
//   frame_start          pulse, starts a frame (IDLE only)
//   frame_last           pulse, no more triangles this frame (RUN only)
//   tri_issue_en         upstream may issue triangles
//   fe_ready, fe_dv      front-end status / setup valid
//   fe_next              front-end accept strobe (combinational)
//   fe_*                 front-end setup payload
//   be_*                 registered payload broadcast to all back-ends
//   be_start             one-hot start strobe, one cycle
//   be_busy              per back-end busy
//   tri_count            dispatched triangles this frame (saturating)
//   frame_busy           frame in progress
//   frame_done           one-cycle completion pulse
// ---------------------------------------------------------------------------
module rasterizer_scheduler
    import rasterizer_pkg::*;
#(
    parameter int DATAWIDTH    = 12,
    parameter int NUM_BACKENDS = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    frame_start,
    input  logic                    frame_last,
    output logic                    tri_issue_en,
    input  logic                    fe_ready,
    input  logic                    fe_dv,
    output logic                    fe_next,
    input  logic [DATAWIDTH-1:0]    fe_bb_tl       [2],
    input  logic [DATAWIDTH-1:0]    fe_bb_br       [2],
    input  logic [DATAWIDTH-1:0]    fe_edge_val0,
    input  logic [DATAWIDTH-1:0]    fe_edge_val1,
    input  logic [DATAWIDTH-1:0]    fe_edge_val2,
    input  logic [DATAWIDTH-1:0]    fe_edge_delta0 [2],
    input  logic [DATAWIDTH-1:0]    fe_edge_delta1 [2],
    input  logic [DATAWIDTH-1:0]    fe_edge_delta2 [2],
    input  logic [DATAWIDTH-1:0]    fe_area_inv,
    output logic [DATAWIDTH-1:0]    be_bb_tl       [2],
    output logic [DATAWIDTH-1:0]    be_bb_br       [2],
    output logic [DATAWIDTH-1:0]    be_edge_val0,
    output logic [DATAWIDTH-1:0]    be_edge_val1,
    output logic [DATAWIDTH-1:0]    be_edge_val2,
    output logic [DATAWIDTH-1:0]    be_edge_delta0 [2],
    output logic [DATAWIDTH-1:0]    be_edge_delta1 [2],
    output logic [DATAWIDTH-1:0]    be_edge_delta2 [2],
    output logic [DATAWIDTH-1:0]    be_area_inv,
    output logic [NUM_BACKENDS-1:0] be_start,
    input  logic [NUM_BACKENDS-1:0] be_busy,
    output logic [CNT_WIDTH-1:0]    tri_count,
    output logic                    frame_busy,
    output logic                    frame_done
);

    localparam int unsigned IW = idx_width(NUM_BACKENDS);

    // The setup struct is sized by the package; the port width must agree.
    if (DATAWIDTH != int'(SETUP_DW)) begin : g_bad_width
        $error("DATAWIDTH must equal rasterizer_pkg::SETUP_DW");
    end

    sched_state_t            state;
    sched_state_t            state_nxt;
    logic                    last_seen;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           ptr_nxt;
    logic [NUM_BACKENDS-1:0] free_mask;
    logic [NUM_BACKENDS-1:0] grant;
    logic [IW-1:0]           grant_idx;
    logic                    grant_valid;
    logic                    dispatch;
    logic                    finish;
    tri_setup_t              setup_in;
    tri_setup_t              setup_q;

    // A back-end strobed last cycle may not show busy yet, so it is not free.
    assign free_mask = ~be_busy & ~be_start;

    rr_arbiter #(
        .N  (NUM_BACKENDS),
        .IW (IW)
    ) u_arb (
        .free  (free_mask),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .valid (grant_valid)
    );

    assign dispatch = (state == ST_RUN) && fe_dv && grant_valid;
    assign ptr_nxt  = (32'(grant_idx) == 32'(NUM_BACKENDS - 1)) ? '0 : grant_idx + 1'b1;

    // frame_last counts toward completion in the same cycle it arrives.
    assign finish = (last_seen || frame_last) && fe_ready && !fe_dv &&
                    (be_start == '0) && (be_busy == '0);

    always_comb begin
        setup_in                  = '0;
        setup_in.bb_tl[0]         = fe_bb_tl[0];
        setup_in.bb_tl[1]         = fe_bb_tl[1];
        setup_in.bb_br[0]         = fe_bb_br[0];
        setup_in.bb_br[1]         = fe_bb_br[1];
        setup_in.edge_val[0]      = fe_edge_val0;
        setup_in.edge_val[1]      = fe_edge_val1;
        setup_in.edge_val[2]      = fe_edge_val2;
        setup_in.edge_delta[0][0] = fe_edge_delta0[0];
        setup_in.edge_delta[0][1] = fe_edge_delta0[1];
        setup_in.edge_delta[1][0] = fe_edge_delta1[0];
        setup_in.edge_delta[1][1] = fe_edge_delta1[1];
        setup_in.edge_delta[2][0] = fe_edge_delta2[0];
        setup_in.edge_delta[2][1] = fe_edge_delta2[1];
        setup_in.area_inv         = fe_area_inv;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (frame_start) state_nxt = ST_RUN;
            ST_RUN:  if (finish)      state_nxt = ST_DONE;
            ST_DONE:                  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tri_issue_en = (state == ST_RUN) && !last_seen;
        fe_next      = dispatch;
        frame_busy   = (state != ST_IDLE);
        frame_done   = (state == ST_DONE);
    end

    // Frame bookkeeping and dispatch registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_seen <= 1'b0;
            rr_ptr    <= '0;
            tri_count <= '0;
            be_start  <= '0;
            setup_q   <= '0;
        end else begin
            be_start <= '0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        tri_count <= '0;
                        last_seen <= 1'b0;
                        rr_ptr    <= '0;
                    end
                end
                ST_RUN: begin
                    last_seen <= last_seen | frame_last;
                    if (dispatch) begin
                        be_start <= grant;
                        setup_q  <= setup_in;
                        rr_ptr   <= ptr_nxt;
                        if (tri_count != '1) begin
                            tri_count <= tri_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign be_bb_tl[0]       = setup_q.bb_tl[0];
    assign be_bb_tl[1]       = setup_q.bb_tl[1];
    assign be_bb_br[0]       = setup_q.bb_br[0];
    assign be_bb_br[1]       = setup_q.bb_br[1];
    assign be_edge_val0      = setup_q.edge_val[0];
    assign be_edge_val1      = setup_q.edge_val[1];
    assign be_edge_val2      = setup_q.edge_val[2];
    assign be_edge_delta0[0] = setup_q.edge_delta[0][0];
    assign be_edge_delta0[1] = setup_q.edge_delta[0][1];
    assign be_edge_delta1[0] = setup_q.edge_delta[1][0];
    assign be_edge_delta1[1] = setup_q.edge_delta[1][1];
    assign be_edge_delta2[0] = setup_q.edge_delta[2][0];
    assign be_edge_delta2[1] = setup_q.edge_delta[2][1];
    assign be_area_inv       = setup_q.area_inv;

endmodule

// File: tb/tb_rasterizer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rasterizer_scheduler
// Directed bench for rasterizer_scheduler with a frame-level reference model,
// emulated front-end handshakes and emulated back-end busy periods.
// ---------------------------------------------------------------------------
module tb_rasterizer_scheduler;

    localparam int DW = 12;
    localparam int NB = 2;
    localparam int CW = 16;
    localparam int PW = 15 * DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_last = 1'b0;
    logic          tri_issue_en;
    logic          fe_ready = 1'b1;
    logic          fe_dv = 1'b0;
    logic          fe_next;
    logic [DW-1:0] fe_bb_tl [2];
    logic [DW-1:0] fe_bb_br [2];
    logic [DW-1:0] fe_edge_val0, fe_edge_val1, fe_edge_val2;
    logic [DW-1:0] fe_edge_delta0 [2];
    logic [DW-1:0] fe_edge_delta1 [2];
    logic [DW-1:0] fe_edge_delta2 [2];
    logic [DW-1:0] fe_area_inv;
    logic [DW-1:0] be_bb_tl [2];
    logic [DW-1:0] be_bb_br [2];
    logic [DW-1:0] be_edge_val0, be_edge_val1, be_edge_val2;
    logic [DW-1:0] be_edge_delta0 [2];
    logic [DW-1:0] be_edge_delta1 [2];
    logic [DW-1:0] be_edge_delta2 [2];
    logic [DW-1:0] be_area_inv;
    logic [NB-1:0] be_start;
    logic [NB-1:0] be_busy = '0;
    logic [CW-1:0] tri_count;
    logic          frame_busy;
    logic          frame_done;

    always #5 clk = ~clk;

    rasterizer_scheduler #(
        .DATAWIDTH    (DW),
        .NUM_BACKENDS (NB),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .frame_start    (frame_start),
        .frame_last     (frame_last),
        .tri_issue_en   (tri_issue_en),
        .fe_ready       (fe_ready),
        .fe_dv          (fe_dv),
        .fe_next        (fe_next),
        .fe_bb_tl       (fe_bb_tl),
        .fe_bb_br       (fe_bb_br),
        .fe_edge_val0   (fe_edge_val0),
        .fe_edge_val1   (fe_edge_val1),
        .fe_edge_val2   (fe_edge_val2),
        .fe_edge_delta0 (fe_edge_delta0),
        .fe_edge_delta1 (fe_edge_delta1),
        .fe_edge_delta2 (fe_edge_delta2),
        .fe_area_inv    (fe_area_inv),
        .be_bb_tl       (be_bb_tl),
        .be_bb_br       (be_bb_br),
        .be_edge_val0   (be_edge_val0),
        .be_edge_val1   (be_edge_val1),
        .be_edge_val2   (be_edge_val2),
        .be_edge_delta0 (be_edge_delta0),
        .be_edge_delta1 (be_edge_delta1),
        .be_edge_delta2 (be_edge_delta2),
        .be_area_inv    (be_area_inv),
        .be_start       (be_start),
        .be_busy        (be_busy),
        .tri_count      (tri_count),
        .frame_busy     (frame_busy),
        .frame_done     (frame_done)
    );

    logic [PW-1:0] fe_flat, be_flat;
    assign fe_flat = {fe_bb_tl[0], fe_bb_tl[1], fe_bb_br[0], fe_bb_br[1],
                      fe_edge_val0, fe_edge_val1, fe_edge_val2,
                      fe_edge_delta0[0], fe_edge_delta0[1], fe_edge_delta1[0],
                      fe_edge_delta1[1], fe_edge_delta2[0], fe_edge_delta2[1],
                      fe_area_inv};
    assign be_flat = {be_bb_tl[0], be_bb_tl[1], be_bb_br[0], be_bb_br[1],
                      be_edge_val0, be_edge_val1, be_edge_val2,
                      be_edge_delta0[0], be_edge_delta0[1], be_edge_delta1[0],
                      be_edge_delta1[1], be_edge_delta2[0], be_edge_delta2[1],
                      be_area_inv};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase 0 = no frame, 1 = frame open, 2 = completion cycle.
    int            m_phase = 0;
    bit            m_last  = 1'b0;
    int            m_ptr   = 0;
    logic [NB-1:0] m_start = '0;
    logic [CW-1:0] m_cnt   = '0;
    logic [PW-1:0] m_pay   = '0;

    function automatic int pick(input logic [NB-1:0] fr, input int p);
        for (int k = 0; k < NB; k++) begin
            if (fr[(p + k) % NB]) return (p + k) % NB;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        int s;
        bit lastn;
        if (!rstn) begin
            m_phase <= 0;
            m_last  <= 1'b0;
            m_ptr   <= 0;
            m_start <= '0;
            m_cnt   <= '0;
            m_pay   <= '0;
        end else begin
            m_start <= '0;
            if (m_phase == 0) begin
                if (frame_start) begin
                    m_phase <= 1;
                    m_cnt   <= '0;
                    m_last  <= 1'b0;
                    m_ptr   <= 0;
                end
            end else if (m_phase == 1) begin
                s = pick(~be_busy & ~m_start, m_ptr);
                if (fe_dv && s >= 0) begin
                    m_start <= NB'(1) << s;
                    m_pay   <= fe_flat;
                    m_ptr   <= (s + 1) % NB;
                    if (m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
                end
                lastn = m_last || frame_last;
                m_last <= lastn;
                if (lastn && fe_ready && !fe_dv && m_start == '0 && be_busy == '0)
                    m_phase <= 2;
            end else begin
                m_phase <= 0;
            end
        end
    end

    // ---------------- per-cycle compare + logging ----------------
    int            start_log[$];
    int            done_cnt  = 0;
    int            done_tc   = -1;
    int            stall_cnt = 0;
    logic [DW-1:0] cap_tl0, cap_tl1, cap_area;

    initial forever begin
        @(negedge clk);
        #2;
        chk("fe_next",      fe_next,
            (m_phase == 1) && fe_dv && (pick(~be_busy & ~m_start, m_ptr) >= 0));
        chk("tri_issue_en", tri_issue_en, (m_phase == 1) && !m_last);
        chk("frame_busy",   frame_busy, m_phase != 0);
        chk("frame_done",   frame_done, m_phase == 2);
        chk("be_start",     be_start, m_start);
        chk("tri_count",    tri_count, m_cnt);
        chk("payload",      be_flat, m_pay);
        if (be_start != '0) begin
            start_log.push_back(int'(be_start));
            cap_tl0  = be_bb_tl[0];
            cap_tl1  = be_bb_tl[1];
            cap_area = be_area_inv;
        end
        if (frame_done) begin
            done_cnt++;
            done_tc = int'(tri_count);
        end
        if (m_phase == 1 && fe_dv && !fe_next) stall_cnt++;
    end

    // ---------------- back-end emulation ----------------
    int            bcnt[NB];
    int            lat[NB];
    logic [NB-1:0] force_busy = '0;

    initial begin
        for (int i = 0; i < NB; i++) begin
            bcnt[i] = 0;
            lat[i]  = 4;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NB; i++) begin
                if (be_start[i]) bcnt[i] = lat[i];
                else if (bcnt[i] > 0) bcnt[i]--;
                be_busy[i] = force_busy[i] || (bcnt[i] > 0);
            end
        end
    end

    // ---------------- front-end / upstream stimulus ----------------
    task automatic set_payload(input int id);
        fe_bb_tl[0]       = DW'(10 * id);
        fe_bb_tl[1]       = DW'(20 * id);
        fe_bb_br[0]       = DW'(100 + id);
        fe_bb_br[1]       = DW'(200 + id);
        fe_edge_val0      = DW'(300 + id);
        fe_edge_val1      = DW'(301 + id);
        fe_edge_val2      = DW'(302 + id);
        fe_edge_delta0[0] = DW'(400 + id);
        fe_edge_delta0[1] = DW'(401 + id);
        fe_edge_delta1[0] = DW'(410 + id);
        fe_edge_delta1[1] = DW'(411 + id);
        fe_edge_delta2[0] = DW'(420 + id);
        fe_edge_delta2[1] = DW'(421 + id);
        fe_area_inv       = DW'(36 + id);
    endtask

    // Entered and left on a falling edge. Setup takes 3 cycles; a culled
    // triangle never raises fe_dv.
    task automatic send(input int id, input bit culled, input bit last);
        bit hs;
        fe_ready   = 1'b0;
        frame_last = last && culled;
        @(negedge clk);
        frame_last = 1'b0;
        repeat (2) @(negedge clk);
        if (culled) begin
            fe_ready = 1'b1;
            return;
        end
        set_payload(id);
        fe_dv      = 1'b1;
        frame_last = last;
        hs = 1'b0;
        for (int c = 0; c < 200 && !hs; c++) begin
            #4 hs = fe_next;
            @(negedge clk);
            frame_last = 1'b0;
        end
        if (!hs) chk("fe handshake timeout", 0, 1);
        fe_dv    = 1'b0;
        fe_ready = 1'b1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_last();
        frame_last = 1'b1;
        @(negedge clk);
        frame_last = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < 200 && done_cnt == d0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({nm, " frame_done pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        set_payload(0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset be_start",     be_start, 0);
        chk("reset tri_count",    tri_count, 0);
        chk("reset frame_busy",   frame_busy, 0);
        chk("reset tri_issue_en", tri_issue_en, 0);
        chk("reset payload",      be_flat, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // A: three triangles, both back-ends idle
        start_log.delete();
        pulse_start();
        #3 chk("A issue_en after start", tri_issue_en, 1);
        send(1, 0, 0);
        send(2, 0, 0);
        send(3, 0, 1);
        wait_done("A");
        chk("A starts", start_log.size(), 3);
        if (start_log.size() == 3) begin
            chk("A start0", start_log[0], 1);
            chk("A start1", start_log[1], 2);
            chk("A start2", start_log[2], 1);
        end
        chk("A tri_count", done_tc, 3);

        // B: back-end 0 busy at the rotation start
        start_log.delete();
        pulse_start();
        force_busy = 2'b01;
        send(1, 0, 0);
        force_busy = 2'b00;
        send(2, 0, 1);
        wait_done("B");
        chk("B starts", start_log.size(), 2);
        if (start_log.size() == 2) begin
            chk("B start0", start_log[0], 2);
            chk("B start1 (ptr back to 0)", start_log[1], 1);
        end

        // C: both busy for 20 cycles while a setup is waiting
        start_log.delete();
        pulse_start();
        stall_cnt  = 0;
        force_busy = 2'b11;
        fork
            send(1, 0, 1);
            begin
                repeat (23) @(negedge clk);
                force_busy = 2'b00;
            end
        join
        wait_done("C");
        chk("C stall cycles", stall_cnt, 20);
        chk("C starts", start_log.size(), 1);
        chk("C bb_tl0", cap_tl0, 10);
        chk("C bb_tl1", cap_tl1, 20);
        chk("C area_inv", cap_area, 37);

        // D: four triangles, two culled (the last one culled)
        pulse_start();
        send(1, 0, 0);
        send(2, 1, 0);
        send(3, 0, 0);
        send(4, 1, 1);
        wait_done("D");
        chk("D tri_count", done_tc, 2);

        // E: frame_last in IDLE and frame_start in RUN are ignored
        pulse_last();
        repeat (2) @(negedge clk);
        #3 chk("E idle after stray last", frame_busy, 0);
        @(negedge clk);
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (5) @(negedge clk);
        #3 chk("E still running", frame_busy, 1);
        chk("E issue_en", tri_issue_en, 1);
        @(negedge clk);
        pulse_last();
        wait_done("E");
        chk("E tri_count", done_tc, 0);

        // F: reset while be_start is high
        pulse_start();
        send(5, 0, 0);
        #1 chk("F be_start pre-reset", be_start, 1);
        rstn = 1'b0;
        #1;
        chk("F be_start in reset",   be_start, 0);
        chk("F tri_count in reset",  tri_count, 0);
        chk("F frame_busy in reset", frame_busy, 0);
        chk("F payload in reset",    be_flat, 0);
        chk("F issue_en in reset",   tri_issue_en, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("F idle after reset",      frame_busy, 0);
        chk("F tri_count after reset", tri_count, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
